// File: rtl/uart_led_ctrl_if.sv
// Byte-stream link between a UART core and the LED controller.
// The master side feeds received bytes and the TX busy flag; the slave side returns response bytes.
interface uart_led_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_TX_Active;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;

  modport master (
    output i_RX_DV,
    output i_RX_Byte,
    output i_TX_Active,
    input  o_TX_DV,
    input  o_TX_Byte
  );

  modport slave (
    input  i_RX_DV,
    input  i_RX_Byte,
    input  i_TX_Active,
    output o_TX_DV,
    output o_TX_Byte
  );
endinterface

// File: rtl/uart_led_ctrl.sv
// UART command parser driving per-channel PWM/blink LEDs, a 1 Hz tick with seconds counter,
// and a one-entry response buffer toward the transmitter.
module uart_led_ctrl #(
  parameter int N_CH         = 3,
  parameter int PWM_W        = 8,
  parameter int ACC_W        = 32,
  parameter int TICK_INC     = 172,
  parameter int TIMEOUT_CLKS = 2500000
) (
  input  logic            i_Clock,
  input  logic            i_Rst_L,
  uart_led_ctrl_if.slave  uart,
  output logic [N_CH-1:0] o_LED_L,
  output logic            o_Tick,
  output logic [5:0]      o_Secs,
  output logic            o_Overrun
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [ACC_W:0]   INC_EXT  = (ACC_W + 1)'(TICK_INC);
  localparam logic [7:0]       N_CH_B   = 8'(N_CH);

  localparam logic [7:0] CHR_S  = 8'h53;
  localparam logic [7:0] CHR_B  = 8'h42;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_E  = 8'h45;
  localparam logic [7:0] CHR_K  = 8'h4B;
  localparam logic [7:0] CHR_T  = 8'h54;
  localparam logic [7:0] CHR_0  = 8'h30;

  typedef enum logic [1:0] {IDLE, GET_CH, GET_VAL} state_t;

  // ---------------- tick / seconds ----------------
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic [5:0]       secs_q, secs_d;

  always_comb begin
    {tick_d, acc_d} = {1'b0, acc_q} + INC_EXT;
    secs_d = secs_q;
    if (secs_q >= 6'd60) begin
      secs_d = 6'd0;
    end else if (tick_q) begin
      secs_d = (secs_q == 6'd59) ? 6'd0 : secs_q + 6'd1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
      secs_q <= 6'd0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
      secs_q <= secs_d;
    end
  end

  assign o_Tick = tick_q;
  assign o_Secs = secs_q;

  // ---------------- command parser ----------------
  state_t          state_q, state_d;
  logic            cmd_blink_q, cmd_blink_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic            resp_vld;
  logic [7:0]      resp_byte;
  logic            duty_we;
  logic            blink_we;
  logic [7:0]      ch_idx;
  logic            ch_ok;

  assign ch_idx = uart.i_RX_Byte - CHR_0;
  assign ch_ok  = (uart.i_RX_Byte >= CHR_0) && (ch_idx < N_CH_B);

  always_comb begin
    state_d     = state_q;
    cmd_blink_d = cmd_blink_q;
    ch_d        = ch_q;
    tmo_d       = tmo_q;
    resp_vld    = 1'b0;
    resp_byte   = 8'h00;
    duty_we     = 1'b0;
    blink_we    = 1'b0;
    if (uart.i_RX_DV) begin
      // A byte always restarts the silence counter, even on the timeout cycle itself.
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (uart.i_RX_Byte == CHR_S || uart.i_RX_Byte == CHR_B) begin
            cmd_blink_d = (uart.i_RX_Byte == CHR_B);
            state_d     = GET_CH;
          end else if (uart.i_RX_Byte != CHR_CR && uart.i_RX_Byte != CHR_LF) begin
            resp_vld  = 1'b1;
            resp_byte = CHR_E;
          end
        end
        GET_CH: begin
          if (ch_ok) begin
            ch_d    = ch_idx[CH_W-1:0];
            state_d = GET_VAL;
          end else begin
            resp_vld  = 1'b1;
            resp_byte = CHR_E;
            state_d   = IDLE;
          end
        end
        GET_VAL: begin
          duty_we   = ~cmd_blink_q;
          blink_we  = cmd_blink_q;
          resp_vld  = 1'b1;
          resp_byte = CHR_K;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d     = '0;
        state_d   = IDLE;
        resp_vld  = 1'b1;
        resp_byte = CHR_T;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      cmd_blink_q <= 1'b0;
      ch_q        <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_blink_q <= cmd_blink_d;
      ch_q        <= ch_d;
      tmo_q       <= tmo_d;
    end
  end

  // ---------------- response buffer ----------------
  logic       full_q, full_d;
  logic [7:0] entry_q, entry_d;
  logic [7:0] last_q, last_d;
  logic       ovr_q, ovr_d;
  logic       tx_fire;

  assign tx_fire = full_q & ~uart.i_TX_Active;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    if (tx_fire) begin
      full_d = 1'b0;
      last_d = entry_q;
    end
    // The slot being launched this cycle counts as free for a new response.
    if (resp_vld) begin
      if (full_q && !tx_fire) begin
        ovr_d = 1'b1;
      end else begin
        full_d  = 1'b1;
        entry_d = resp_byte;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      full_q  <= 1'b0;
      entry_q <= 8'h00;
      last_q  <= 8'h00;
      ovr_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign uart.o_TX_DV   = tx_fire;
  assign uart.o_TX_Byte = tx_fire ? entry_q : last_q;
  assign o_Overrun      = ovr_q;

  // ---------------- PWM ----------------
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             pwm_wrap;
  logic             phase;
  logic [PWM_W-1:0] duty_val;

  assign pwm_d    = pwm_q + 1'b1;
  assign pwm_wrap = &pwm_q;
  assign phase    = acc_q[ACC_W-1];
  assign duty_val = PWM_W'(uart.i_RX_Byte);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [PWM_W-1:0] shadow_q, shadow_d;
    logic [PWM_W-1:0] active_q, active_d;
    logic             blink_q, blink_d;
    logic             led_q, led_d;
    logic             sel;

    always_comb begin
      sel      = (ch_q == CH_W'(gi));
      shadow_d = (duty_we && sel) ? duty_val : shadow_q;
      blink_d  = (blink_we && sel) ? (uart.i_RX_Byte != 8'h00) : blink_q;
      // Active duty only changes at the wrap, so a period is never cut short.
      active_d = pwm_wrap ? shadow_q : active_q;
      led_d    = ~((pwm_q < active_q) && (~blink_q || phase));
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        shadow_q <= '0;
        active_q <= '0;
        blink_q  <= 1'b0;
        led_q    <= 1'b1;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        blink_q  <= blink_d;
        led_q    <= led_d;
      end
    end

    assign o_LED_L[gi] = led_q;
  end

endmodule

// File: doc/uart_led_ctrl.md
UART_LED_CTRL -- requirements
Module: uart_led_ctrl

Interface
REQ-001 Parameter N_CH, default 3, number of LED channels (1..8).
REQ-002 Parameter PWM_W, default 8, PWM counter and duty width.
REQ-003 Parameter ACC_W, default 32, tick phase-accumulator width.
REQ-004 Parameter TICK_INC, default 172, accumulator increment per clock (about 1 Hz at 25 MHz).
REQ-005 Parameter TIMEOUT_CLKS, default 2500000, clocks of inter-byte silence that abort a frame.
REQ-006 i_Clock  in  1  sole clock; every register is clocked on its rising edge.
REQ-007 i_Rst_L  in  1  reset, asynchronous assert, active-low.
REQ-008 i_RX_DV  in  1  one-cycle strobe; i_RX_Byte is valid.
REQ-009 i_RX_Byte  in  8  received byte.
REQ-010 i_TX_Active  in  1  transmitter busy.
REQ-011 o_TX_DV  out  1  one-cycle strobe launching o_TX_Byte.
REQ-012 o_TX_Byte  out  8  response byte.
REQ-013 o_LED_L  out  N_CH  LED drives, active-low (0 = lit).
REQ-014 o_Tick  out  1  one-cycle pulse on accumulator carry-out.
REQ-015 o_Secs  out  6  seconds count, 0..59.
REQ-016 o_Overrun  out  1  sticky flag: a response was dropped.

Function
REQ-017 Tick: {carry, acc} <= acc + TICK_INC every cycle; o_Tick = registered carry; acc wraps modulo 2^ACC_W.
REQ-018 Blink phase = acc[ACC_W-1].
REQ-019 o_Secs: +1 per o_Tick; on o_Tick at 59 -> 0; any value >= 60 -> 0 on the next cycle.
REQ-020 Parser states: IDLE, GET_CH, GET_VAL; only cycles with i_RX_DV = 1 advance the parser.
REQ-021 IDLE: 'S' (0x53) or 'B' (0x42) -> latch command, go to GET_CH.
REQ-022 IDLE: 0x0D or 0x0A -> ignored, no response.
REQ-023 IDLE: any other byte -> response 'E' (0x45), stay in IDLE.
REQ-024 GET_CH: byte minus 0x30 < N_CH -> latch channel, go to GET_VAL.
REQ-025 GET_CH: any other byte -> response 'E', go to IDLE.
REQ-026 GET_VAL, 'S': shadow duty[ch] <= byte[PWM_W-1:0]; PWM_W > 8 zero-extends the byte.
REQ-027 GET_VAL, 'B': blink[ch] <= (byte != 0).
REQ-028 GET_VAL, either command: response 'K' (0x4B), go to IDLE.
REQ-029 Timeout counter clears on every i_RX_DV and counts in GET_CH and GET_VAL.
REQ-030 Timeout counter reaching TIMEOUT_CLKS-1 with no byte -> IDLE, response 'T' (0x54).
REQ-031 A byte arriving on the timeout cycle wins: it is parsed, and the timeout is not taken.
REQ-032 PWM: free-running PWM_W-bit counter pwm_cnt wraps from all-ones to 0.
REQ-033 active duty[ch] <= shadow duty[ch] only in the cycle where pwm_cnt is all-ones.
REQ-034 A shadow write in that same cycle takes effect at the following wrap.
REQ-035 lit[ch] = (pwm_cnt < active duty[ch]) AND (blink[ch] = 0 OR phase = 1).
REQ-036 o_LED_L[ch] = NOT lit[ch], registered.
REQ-037 Duty 0 -> never lit; duty all-ones -> lit for 2^PWM_W - 1 of 2^PWM_W counts.
REQ-038 Response buffer is one entry deep.
REQ-039 A response is produced one cycle after the byte that causes it.
REQ-040 Buffer full and i_TX_Active = 0 -> o_TX_DV = 1 with o_TX_Byte = entry for one cycle; entry freed the same cycle.
REQ-041 Entry held while i_TX_Active = 1.
REQ-042 New response with the entry still occupied -> new response dropped, old entry kept, o_Overrun <= 1.
REQ-043 o_Overrun clears only on reset.
REQ-044 o_TX_Byte holds its last value when o_TX_DV = 0.

Reset
REQ-045 i_Rst_L = 0 asynchronously forces: parser IDLE, timeout counter 0, acc 0, pwm_cnt 0.
REQ-046 Reset also forces: all shadow and active duties 0, all blink 0, response buffer empty.
REQ-047 Output reset values: o_LED_L all ones, o_Tick 0, o_Secs 0, o_TX_DV 0, o_TX_Byte 0x00, o_Overrun 0.
REQ-048 Reset mid-frame discards the partial command with no response.
REQ-049 Operation resumes on the first rising edge of i_Clock after i_Rst_L deasserts.

Verification
REQ-050 Bytes 'S','1',0x80 with PWM_W=8 -> exactly one 'K' strobe; from the next wrap, o_LED_L[1] is low for 128 of every 256 clocks; other channels stay high.
REQ-051 Bytes 'S','7' with N_CH=3 -> 'E', parser in IDLE; a following 'Q' -> 'E'; 0x0A -> no strobe.
REQ-052 With ACC_W=8, TICK_INC=64 -> o_Tick every 4 clocks; o_Secs wraps 59 -> 0 after 60 ticks; after 'B','0',0x01 with duty 255, LED 0 lights only while acc[7] = 1.
REQ-053 With TIMEOUT_CLKS=16: 'S' then 16 idle clocks -> 'T' and IDLE; a repeat with a byte on clock 15 -> no 'T'.
REQ-054 Hold i_TX_Active = 1 and send two bad bytes -> one 'E' held, o_Overrun = 1; release i_TX_Active -> a single 'E' strobe.
REQ-055 Assert i_Rst_L = 0 after 'S','2' -> all outputs at reset values immediately; after release, 0x80 -> 'E'.
